// File: rtl/gpr_wb_ctrl.sv
// gpr_wb_ctrl: GPR writeback controller.
// Purpose: arbitrates load, ALU and MDU results onto the single GPR write port,
// formats load data (sign/zero extension, LWL/LWR merges) into register-ready
// words with byte enables, and keeps a per-register busy scoreboard used by the
// issue stage for interlock.
// Ports:
//   clk, reset                     clock and synchronous active-high reset
//   ld_valid/addr/type/off/data    load return (never back-pressured, ld_ready=1)
//   alu_valid/addr/data, alu_ready ALU result handshake
//   mdu_valid/addr/data, mdu_ready multiply/divide result handshake
//   iss_valid, iss_addr            issuing instruction with a GPR destination
//   busy                           scoreboard, bit i = GPR i has a pending write
//   rd_addr, rd_in, rd_byte_w_en,
//   write                          registered GPR write port
module gpr_wb_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ld_valid,
  input  logic [ADDR_WIDTH-1:0]    ld_addr,
  input  logic [2:0]               ld_type,
  input  logic [1:0]               ld_off,
  input  logic [DATA_WIDTH-1:0]    ld_data,
  output logic                     ld_ready,
  input  logic                     alu_valid,
  input  logic [ADDR_WIDTH-1:0]    alu_addr,
  input  logic [DATA_WIDTH-1:0]    alu_data,
  output logic                     alu_ready,
  input  logic                     mdu_valid,
  input  logic [ADDR_WIDTH-1:0]    mdu_addr,
  input  logic [DATA_WIDTH-1:0]    mdu_data,
  output logic                     mdu_ready,
  input  logic                     iss_valid,
  input  logic [ADDR_WIDTH-1:0]    iss_addr,
  output logic [2**ADDR_WIDTH-1:0] busy,
  output logic [ADDR_WIDTH-1:0]    rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_in,
  output logic [3:0]               rd_byte_w_en,
  output logic                     write
);

  localparam int NREG = 2**ADDR_WIDTH;

  localparam logic [2:0] LD_LB  = 3'd0;
  localparam logic [2:0] LD_LBU = 3'd1;
  localparam logic [2:0] LD_LH  = 3'd2;
  localparam logic [2:0] LD_LHU = 3'd3;
  localparam logic [2:0] LD_LWL = 3'd5;
  localparam logic [2:0] LD_LWR = 3'd6;

  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_word;
  logic [3:0]            ld_en;

  logic                  accept;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [3:0]            sel_en;
  logic [NREG-1:0]       busy_next;

  // Fixed priority load > ALU > MDU; loads are never stalled.
  assign ld_ready  = 1'b1;
  assign alu_ready = !ld_valid;
  assign mdu_ready = !ld_valid && !alu_valid;

  // Load formatting. Halfword loads ignore ld_off[0] (alignment is checked
  // upstream). For LWL the shift amount 3-b equals ~b on two bits.
  always_comb begin
    ld_byte = ld_data[{ld_off, 3'b000} +: 8];
    ld_half = ld_data[{ld_off[1], 4'b0000} +: 16];
    ld_word = ld_data;
    ld_en   = 4'b1111;
    case (ld_type)
      LD_LB:  ld_word = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
      LD_LBU: ld_word = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
      LD_LH:  ld_word = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
      LD_LHU: ld_word = {{(DATA_WIDTH-16){1'b0}}, ld_half};
      LD_LWL: begin
        ld_word = ld_data << {~ld_off, 3'b000};
        ld_en   = 4'b1111 << (~ld_off);
      end
      LD_LWR: begin
        ld_word = ld_data >> {ld_off, 3'b000};
        ld_en   = 4'b1111 >> ld_off;
      end
      default: ld_word = ld_data;
    endcase
  end

  always_comb begin
    accept   = 1'b1;
    sel_addr = ld_addr;
    sel_data = ld_word;
    sel_en   = ld_en;
    if (ld_valid) begin
      sel_addr = ld_addr;
    end else if (alu_valid) begin
      sel_addr = alu_addr;
      sel_data = alu_data;
      sel_en   = 4'b1111;
    end else if (mdu_valid) begin
      sel_addr = mdu_addr;
      sel_data = mdu_data;
      sel_en   = 4'b1111;
    end else begin
      accept = 1'b0;
    end
  end

  // Clear for the write retiring this cycle, then set for the new issue so a
  // newer producer to the same register keeps it busy.
  always_comb begin
    busy_next = busy;
    if (write) busy_next[rd_addr] = 1'b0;
    if (iss_valid && (iss_addr != '0)) busy_next[iss_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Enables are forced to 0 whenever write is 0 so bypass logic never sees
  // stale enables; address and data simply hold when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr      <= '0;
      rd_in        <= '0;
      rd_byte_w_en <= 4'b0000;
      write        <= 1'b0;
      busy         <= '0;
    end else begin
      busy <= busy_next;
      if (accept) begin
        rd_addr      <= sel_addr;
        rd_in        <= sel_data;
        write        <= (sel_addr != '0);
        rd_byte_w_en <= (sel_addr != '0) ? sel_en : 4'b0000;
      end else begin
        write        <= 1'b0;
        rd_byte_w_en <= 4'b0000;
      end
    end
  end

endmodule

// File: tb/tb_gpr_wb_ctrl.sv
// tb_gpr_wb_ctrl: self-checking bench for gpr_wb_ctrl.
// Directed table of vectors with expected outputs, a hand-written reset
// sequence, and a randomized phase checked against a behavioural model.
module tb_gpr_wb_ctrl;

  logic        clk;
  logic        reset;
  logic        ld_valid;
  logic [4:0]  ld_addr;
  logic [2:0]  ld_type;
  logic [1:0]  ld_off;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mdu_valid;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic [31:0] busy;
  logic [4:0]  rd_addr;
  logic [31:0] rd_in;
  logic [3:0]  rd_byte_w_en;
  logic        write;

  gpr_wb_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_type(ld_type), .ld_off(ld_off),
    .ld_data(ld_data), .ld_ready(ld_ready),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .busy(busy),
    .rd_addr(rd_addr), .rd_in(rd_in), .rd_byte_w_en(rd_byte_w_en), .write(write)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic        ldv;
    logic [4:0]  lda;
    logic [2:0]  ldt;
    logic [1:0]  ldo;
    logic [31:0] ldd;
    logic        alv;
    logic [4:0]  ala;
    logic [31:0] ald;
    logic        mdv;
    logic [4:0]  mda;
    logic [31:0] mdd;
    logic        isv;
    logic [4:0]  isa;
    logic        e_alr;
    logic        e_mdr;
    logic        e_wr;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [3:0]  e_en;
    logic [31:0] e_busy;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (what the write port / scoreboard should show).
  logic        m_wr, n_wr;
  logic [4:0]  m_addr, n_addr;
  logic [31:0] m_data, n_data;
  logic [3:0]  m_en, n_en;
  logic [31:0] m_busy, n_busy;

  function automatic vec_t blank();
    vec_t v;
    v.rst = 0; v.ldv = 0; v.lda = 0; v.ldt = 0; v.ldo = 0; v.ldd = 0;
    v.alv = 0; v.ala = 0; v.ald = 0; v.mdv = 0; v.mda = 0; v.mdd = 0;
    v.isv = 0; v.isa = 0; v.e_alr = 0; v.e_mdr = 0; v.e_wr = 0;
    v.e_addr = 0; v.e_data = 0; v.e_en = 0; v.e_busy = 0;
    return v;
  endfunction

  function automatic vec_t mk(
    input logic ldv, input logic [4:0] lda, input logic [2:0] ldt,
    input logic [1:0] ldo, input logic [31:0] ldd,
    input logic alv, input logic [4:0] ala, input logic [31:0] ald,
    input logic mdv, input logic [4:0] mda, input logic [31:0] mdd,
    input logic isv, input logic [4:0] isa,
    input logic e_alr, input logic e_mdr, input logic e_wr,
    input logic [4:0] e_addr, input logic [31:0] e_data,
    input logic [3:0] e_en, input logic [31:0] e_busy);
    vec_t v;
    v = blank();
    v.ldv = ldv; v.lda = lda; v.ldt = ldt; v.ldo = ldo; v.ldd = ldd;
    v.alv = alv; v.ala = ala; v.ald = ald;
    v.mdv = mdv; v.mda = mda; v.mdd = mdd;
    v.isv = isv; v.isa = isa;
    v.e_alr = e_alr; v.e_mdr = e_mdr; v.e_wr = e_wr;
    v.e_addr = e_addr; v.e_data = e_data; v.e_en = e_en; v.e_busy = e_busy;
    return v;
  endfunction

  // Load formatting expressed byte by byte from the little-endian memory word.
  task automatic formatLoad(input logic [2:0] t, input logic [1:0] off,
                            input logic [31:0] d,
                            output logic [31:0] r, output logic [3:0] en);
    logic [7:0]  mb [4];
    logic [7:0]  rb [4];
    logic [15:0] h;
    int          b;
    int          sh;
    b = int'(off);
    for (int i = 0; i < 4; i++) begin
      mb[i] = d[8*i +: 8];
      rb[i] = 8'h00;
    end
    en = 4'b1111;
    case (t)
      3'd0: r = {{24{mb[b][7]}}, mb[b]};
      3'd1: r = {24'h0, mb[b]};
      3'd2, 3'd3: begin
        h = (b >= 2) ? {mb[3], mb[2]} : {mb[1], mb[0]};
        r = (t == 3'd2) ? {{16{h[15]}}, h} : {16'h0, h};
      end
      3'd5: begin
        sh = 3 - b;
        for (int i = 0; i < 4; i++) begin
          en[i] = (i >= sh);
          if (i >= sh) rb[i] = mb[i - sh];
        end
        r = {rb[3], rb[2], rb[1], rb[0]};
      end
      3'd6: begin
        for (int i = 0; i < 4; i++) begin
          en[i] = (i + b <= 3);
          if (i + b <= 3) rb[i] = mb[i + b];
        end
        r = {rb[3], rb[2], rb[1], rb[0]};
      end
      default: r = d;
    endcase
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drives one cycle's inputs at the falling edge and computes the model's
  // next state from them.
  task automatic applyStimulus(input vec_t v);
    logic [31:0] fd;
    logic [3:0]  fe;
    logic        acc;
    logic [4:0]  a;
    logic [31:0] d;
    logic [3:0]  e;
    @(negedge clk);
    reset = v.rst;
    ld_valid = v.ldv; ld_addr = v.lda; ld_type = v.ldt; ld_off = v.ldo; ld_data = v.ldd;
    alu_valid = v.alv; alu_addr = v.ala; alu_data = v.ald;
    mdu_valid = v.mdv; mdu_addr = v.mda; mdu_data = v.mdd;
    iss_valid = v.isv; iss_addr = v.isa;
    formatLoad(v.ldt, v.ldo, v.ldd, fd, fe);
    acc = 1'b1; a = 0; d = 0; e = 0;
    if (v.ldv) begin a = v.lda; d = fd; e = fe; end
    else if (v.alv) begin a = v.ala; d = v.ald; e = 4'hF; end
    else if (v.mdv) begin a = v.mda; d = v.mdd; e = 4'hF; end
    else acc = 1'b0;
    n_busy = m_busy;
    if (m_wr) n_busy[m_addr] = 1'b0;
    if (v.isv && v.isa != 0) n_busy[v.isa] = 1'b1;
    n_busy[0] = 1'b0;
    if (v.rst) begin
      n_wr = 0; n_addr = 0; n_data = 0; n_en = 0; n_busy = 0;
    end else if (acc) begin
      n_wr = (a != 0); n_addr = a; n_data = d; n_en = (a != 0) ? e : 4'h0;
    end else begin
      n_wr = 0; n_addr = m_addr; n_data = m_data; n_en = 0;
    end
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    m_wr = n_wr; m_addr = n_addr; m_data = n_data; m_en = n_en; m_busy = n_busy;
  endtask

  vec_t tbl [24];
  vec_t v;

  initial begin
    m_wr = 0; m_addr = 0; m_data = 0; m_en = 0; m_busy = 0;
    reset = 1; ld_valid = 0; ld_addr = 0; ld_type = 0; ld_off = 0; ld_data = 0;
    alu_valid = 0; alu_addr = 0; alu_data = 0; mdu_valid = 0; mdu_addr = 0;
    mdu_data = 0; iss_valid = 0; iss_addr = 0;

    // Reset while every register is busy and a write is on the port.
    v = blank(); v.rst = 1;
    applyStimulus(v); tick();
    checkOutput("init_write", {31'b0, write}, 32'h0);
    checkOutput("init_busy", busy, 32'h0);
    for (int i = 1; i < 32; i++) begin
      v = blank(); v.isv = 1; v.isa = 5'(i);
      applyStimulus(v); tick();
    end
    checkOutput("busy_all", busy, 32'hFFFF_FFFE);
    v = blank(); v.alv = 1; v.ala = 5'd3; v.ald = 32'h55;
    applyStimulus(v); tick();
    checkOutput("pre_rst_write", {31'b0, write}, 32'h1);
    checkOutput("pre_rst_busy", busy, 32'hFFFF_FFFE);
    v = blank(); v.rst = 1;
    applyStimulus(v); tick();
    checkOutput("rst_write", {31'b0, write}, 32'h0);
    checkOutput("rst_en", {28'b0, rd_byte_w_en}, 32'h0);
    checkOutput("rst_busy", busy, 32'h0);

    // ldv lda ldt ldo ldd | alv ala ald | mdv mda mdd | isv isa | alr mdr wr addr data en busy
    tbl[0]  = mk(1,5,0,2,32'h1280_3456, 0,0,0, 0,0,0, 0,0, 0,0,1,5,32'hFFFF_FF80,4'hF,32'h0);
    tbl[1]  = mk(1,7,5,1,32'hAABB_CCDD, 0,0,0, 0,0,0, 0,0, 0,0,1,7,32'hCCDD_0000,4'hC,32'h0);
    tbl[2]  = mk(1,7,6,1,32'hAABB_CCDD, 0,0,0, 0,0,0, 0,0, 0,0,1,7,32'h00AA_BBCC,4'h7,32'h0);
    tbl[3]  = mk(1,1,1,3,32'h8000_0000, 0,0,0, 0,0,0, 0,0, 0,0,1,1,32'h0000_0080,4'hF,32'h0);
    tbl[4]  = mk(1,2,2,3,32'h8001_1234, 0,0,0, 0,0,0, 0,0, 0,0,1,2,32'hFFFF_8001,4'hF,32'h0);
    tbl[5]  = mk(1,2,3,1,32'h0000_9ABC, 0,0,0, 0,0,0, 0,0, 0,0,1,2,32'h0000_9ABC,4'hF,32'h0);
    tbl[6]  = mk(1,3,7,2,32'h1234_5678, 0,0,0, 0,0,0, 0,0, 0,0,1,3,32'h1234_5678,4'hF,32'h0);
    tbl[7]  = mk(1,4,4,0,32'h1111_1111, 1,6,32'h2222_2222, 1,8,32'h3333_3333, 0,0, 0,0,1,4,32'h1111_1111,4'hF,32'h0);
    tbl[8]  = mk(0,0,0,0,0, 1,6,32'h2222_2222, 1,8,32'h3333_3333, 0,0, 1,0,1,6,32'h2222_2222,4'hF,32'h0);
    tbl[9]  = mk(0,0,0,0,0, 0,0,0, 1,8,32'h3333_3333, 0,0, 1,1,1,8,32'h3333_3333,4'hF,32'h0);
    tbl[10] = mk(0,0,0,0,0, 0,0,0, 0,0,0, 0,0, 1,1,0,0,0,4'h0,32'h0);
    tbl[11] = mk(0,0,0,0,0, 0,0,0, 0,0,0, 1,9, 1,1,0,0,0,4'h0,32'h0000_0200);
    tbl[12] = mk(0,0,0,0,0, 1,9,32'h5, 0,0,0, 0,0, 1,0,1,9,32'h5,4'hF,32'h0000_0200);
    tbl[13] = mk(0,0,0,0,0, 0,0,0, 0,0,0, 0,0, 1,1,0,0,0,4'h0,32'h0);
    tbl[14] = mk(0,0,0,0,0, 0,0,0, 0,0,0, 1,9, 1,1,0,0,0,4'h0,32'h0000_0200);
    tbl[15] = mk(0,0,0,0,0, 1,9,32'h6, 0,0,0, 0,0, 1,0,1,9,32'h6,4'hF,32'h0000_0200);
    tbl[16] = mk(0,0,0,0,0, 0,0,0, 0,0,0, 1,9, 1,1,0,0,0,4'h0,32'h0000_0200);
    tbl[17] = mk(0,0,0,0,0, 1,0,32'hDEAD_BEEF, 0,0,0, 0,0, 1,0,0,0,0,4'h0,32'h0000_0200);
    tbl[18] = mk(0,0,0,0,0, 0,0,0, 0,0,0, 1,0, 1,1,0,0,0,4'h0,32'h0000_0200);
    tbl[19] = mk(1,10,5,0,32'hAABB_CCDD, 0,0,0, 0,0,0, 0,0, 0,0,1,10,32'hDD00_0000,4'h8,32'h0000_0200);
    tbl[20] = mk(1,10,6,3,32'hAABB_CCDD, 0,0,0, 0,0,0, 0,0, 0,0,1,10,32'h0000_00AA,4'h1,32'h0000_0200);
    tbl[21] = mk(1,10,5,3,32'hAABB_CCDD, 0,0,0, 0,0,0, 0,0, 0,0,1,10,32'hAABB_CCDD,4'hF,32'h0000_0200);
    tbl[22] = mk(1,10,6,0,32'hAABB_CCDD, 0,0,0, 0,0,0, 0,0, 0,0,1,10,32'hAABB_CCDD,4'hF,32'h0000_0200);
    tbl[23] = mk(1,11,0,0,32'h0000_007F, 0,0,0, 0,0,0, 0,0, 0,0,1,11,32'h0000_007F,4'hF,32'h0000_0200);

    for (int i = 0; i < 24; i++) begin
      applyStimulus(tbl[i]);
      checkOutput($sformatf("t%0d_ld_ready", i), {31'b0, ld_ready}, 32'h1);
      checkOutput($sformatf("t%0d_alu_ready", i), {31'b0, alu_ready}, {31'b0, tbl[i].e_alr});
      checkOutput($sformatf("t%0d_mdu_ready", i), {31'b0, mdu_ready}, {31'b0, tbl[i].e_mdr});
      tick();
      checkOutput($sformatf("t%0d_write", i), {31'b0, write}, {31'b0, tbl[i].e_wr});
      checkOutput($sformatf("t%0d_en", i), {28'b0, rd_byte_w_en}, {28'b0, tbl[i].e_en});
      checkOutput($sformatf("t%0d_busy", i), busy, tbl[i].e_busy);
      if (tbl[i].e_wr) begin
        checkOutput($sformatf("t%0d_addr", i), {27'b0, rd_addr}, {27'b0, tbl[i].e_addr});
        checkOutput($sformatf("t%0d_data", i), rd_in, tbl[i].e_data);
      end
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      v = blank();
      v.rst = ($urandom_range(0, 49) == 0);
      v.ldv = ($urandom_range(0, 3) == 0);
      v.lda = 5'($urandom_range(0, 31));
      v.ldt = 3'($urandom_range(0, 7));
      v.ldo = 2'($urandom_range(0, 3));
      v.ldd = $urandom;
      v.alv = ($urandom_range(0, 2) == 0);
      v.ala = 5'($urandom_range(0, 31));
      v.ald = $urandom;
      v.mdv = ($urandom_range(0, 2) == 0);
      v.mda = 5'($urandom_range(0, 31));
      v.mdd = $urandom;
      v.isv = ($urandom_range(0, 1) == 0);
      v.isa = 5'($urandom_range(0, 31));
      applyStimulus(v);
      checkOutput("r_alu_ready", {31'b0, alu_ready}, {31'b0, !v.ldv});
      checkOutput("r_mdu_ready", {31'b0, mdu_ready}, {31'b0, !v.ldv && !v.alv});
      tick();
      checkOutput("r_write", {31'b0, write}, {31'b0, m_wr});
      checkOutput("r_en", {28'b0, rd_byte_w_en}, {28'b0, m_en});
      checkOutput("r_busy", busy, m_busy);
      if (m_wr) begin
        checkOutput("r_addr", {27'b0, rd_addr}, {27'b0, m_addr});
        checkOutput("r_data", rd_in, m_data);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gpr_wb_ctrl.md
Name: gpr_wb_ctrl

Overview:
- Writeback controller that drives the GPR write port: rd_addr, rd_in, rd_byte_w_en and write.
- Arbitrates three result sources: load return, ALU/pipeline result, and multiply/divide result.
- Formats load data into register-ready words with byte enables: sign or zero extension, and LWL/LWR merges.
- Keeps a per-register busy scoreboard for issue-stage interlock.

Parameters:
- DATA_WIDTH, 32, GPR data width; fixed at 32 for load formatting.
- ADDR_WIDTH, 5, GPR index width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ld_valid  in  1  load return valid.
- ld_addr  in  ADDR_WIDTH  load destination register.
- ld_type  in  3  load type: 0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR, 7 reserved (treated as LW).
- ld_off  in  2  byte offset of the load address.
- ld_data  in  DATA_WIDTH  raw aligned memory word.
- ld_ready  out  1  tied to 1; loads are never back-pressured.
- alu_valid  in  1  ALU result valid.
- alu_addr  in  ADDR_WIDTH  ALU result destination.
- alu_data  in  DATA_WIDTH  ALU result data.
- alu_ready  out  1  ALU result accepted this cycle.
- mdu_valid  in  1  multiply/divide result valid.
- mdu_addr  in  ADDR_WIDTH  MDU result destination.
- mdu_data  in  DATA_WIDTH  MDU result data.
- mdu_ready  out  1  MDU result accepted this cycle.
- iss_valid  in  1  an instruction with a GPR destination issues this cycle.
- iss_addr  in  ADDR_WIDTH  destination of the issuing instruction.
- busy  out  2**ADDR_WIDTH  scoreboard; bit i set means GPR i has a write pending.
- rd_addr  out  ADDR_WIDTH  GPR write address (registered).
- rd_in  out  DATA_WIDTH  GPR write data (registered).
- rd_byte_w_en  out  4  GPR byte write enables (registered).
- write  out  1  GPR write strobe (registered).

Behaviour:
- Reset (synchronous):
  - rd_addr, rd_in, rd_byte_w_en, write and busy all become 0 at the next edge.
  - Any in-flight result is dropped.
- Arbitration is combinational and fixed priority: load > ALU > MDU.
  - ld_ready = 1.
  - alu_ready = !ld_valid.
  - mdu_ready = !ld_valid && !alu_valid.
  - A source is accepted when valid && ready.
- Latency: a source accepted in cycle N is presented on the write port in cycle N+1 for exactly one cycle.
- If no source is accepted, write = 0 in the next cycle; rd_addr, rd_in and rd_byte_w_en hold their previous values.
- A destination of 0 is accepted and consumed but produces write = 0 and rd_byte_w_en = 0.
- ALU and MDU results: rd_byte_w_en = 4'b1111, rd_in = data.
- Load formatting (little-endian; b = ld_off):
  - LB: rd_in = sign-extended byte b; enable 1111.
  - LBU: rd_in = zero-extended byte b; enable 1111.
  - LH: rd_in = sign-extended halfword at offset {b[1],0}; enable 1111. b[0] is ignored because alignment is checked upstream.
  - LHU: same as LH but zero-extended.
  - LW: rd_in = ld_data; enable 1111.
  - LWL: rd_in = ld_data << 8*(3-b). Enables: b=0 → 1000, b=1 → 1100, b=2 → 1110, b=3 → 1111.
  - LWR: rd_in = ld_data >> 8*b. Enables: b=0 → 1111, b=1 → 0111, b=2 → 0011, b=3 → 0001.
- Scoreboard:
  - iss_valid with iss_addr ≠ 0 sets busy[iss_addr] at the next edge.
  - A cycle with write = 1 clears busy[rd_addr] at the edge ending that cycle.
  - If set and clear hit the same index on the same edge, set wins (the newer producer is still pending).
  - busy[0] is always 0.
  - busy does not depend on results that are accepted but not yet written.
- rd_byte_w_en is already 0 whenever write = 0. The GPR bypass logic therefore sees no stale enables.

Test Plan:
- Reset with busy = 0xFFFF_FFFE and write active → next cycle: write = 0, rd_byte_w_en = 0, busy = 0.
- ld_valid, LB, ld_off = 2, ld_data = 0x12_80_34_56, ld_addr = 5 → next cycle: write = 1, rd_addr = 5, rd_in = 0xFFFF_FF80, rd_byte_w_en = 1111.
- LWL ld_off = 1 and LWR ld_off = 1, both with ld_data = 0xAABBCCDD, on consecutive cycles to addr 7 → LWL write: rd_in = 0xCCDD_0000, enable 1100. LWR write: rd_in = 0x00AA_BBCC, enable 0111.
- ld, alu and mdu all valid in the same cycle → load written first. alu_ready = 0 and mdu_ready = 0 that cycle. ALU and then MDU are written in the following cycles once ld_valid drops.
- iss_valid addr 9 → busy[9] = 1. Later an ALU result to 9 is written → busy[9] = 0. Repeat with iss_valid addr 9 on the same cycle as the write → busy[9] stays 1.
- ALU result to addr 0 with data 0xDEADBEEF → alu_ready = 1, next cycle write = 0, busy unchanged.
